// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared widths, ALU encodings and NOP constant for the core
package core_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  // alu_op classes produced by the control decoder
  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_ARITH  = 2'b10;
  localparam logic [1:0] ALUOP_RSVD   = 2'b11;

  // alu_ctrl operation codes
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - 64-bit integer ALU with zero flag
module alu
  import core_pkg::*;
(
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic [3:0]  ctrl,
  output logic [63:0] result,
  output logic        zero
);

  // Evaluate the selected operation; unknown codes yield zero
  always_comb begin
    result = '0;
    case (ctrl)
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_ADD:  result = a + b;
      ALU_XOR:  result = a ^ b;
      ALU_SLL:  result = a << b[5:0];
      ALU_SRL:  result = a >> b[5:0];
      ALU_SUB:  result = a - b;
      ALU_SRA:  result = $signed(a) >>> b[5:0];
      ALU_SLT:  result = {63'd0, $signed(a) < $signed(b)};
      ALU_SLTU: result = {63'd0, a < b};
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - ALU control decode, operand select and ALU
module execute_stage
  import core_pkg::*;
(
  input  logic [63:0] rs1_data_d2,
  input  logic [63:0] rs2_data_d2,
  input  logic [63:0] immediate_d2,
  input  logic [2:0]  func3_d2,
  input  logic        func7b5_d2,
  input  logic        alu_src_d2,
  input  logic [1:0]  alu_op_d2,
  output logic [3:0]  alu_ctrl,
  output logic [63:0] alu_result,
  output logic        alu_zero
);

  logic [63:0] operand_b;

  // Map the ALU class and function bits to an operation; funct7b5 means SUB only for R-type
  always_comb begin
    alu_ctrl = ALU_ADD;
    case (alu_op_d2)
      ALUOP_MEM:    alu_ctrl = ALU_ADD;
      ALUOP_BRANCH: alu_ctrl = ALU_SUB;
      ALUOP_ARITH: begin
        case (func3_d2)
          3'b000:  alu_ctrl = (func7b5_d2 && !alu_src_d2) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_ctrl = ALU_SLL;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b011:  alu_ctrl = ALU_SLTU;
          3'b100:  alu_ctrl = ALU_XOR;
          3'b101:  alu_ctrl = func7b5_d2 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_ctrl = ALU_OR;
          default: alu_ctrl = ALU_AND;
        endcase
      end
      default:      alu_ctrl = ALU_ADD;
    endcase
  end

  assign operand_b = alu_src_d2 ? immediate_d2 : rs2_data_d2;

  alu u_alu (
    .a      (rs1_data_d2),
    .b      (operand_b),
    .ctrl   (alu_ctrl),
    .result (alu_result),
    .zero   (alu_zero)
  );

endmodule

// File: rtl/idex_reg.sv
// rtl/idex_reg.sv - ID/EX register for operands, fields and control with bubble insertion
module idex_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        idex_bubble,
  input  logic [63:0] rs1_data,
  input  logic [63:0] rs2_data,
  input  logic [63:0] immediate,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic [2:0]  func3,
  input  logic        func7b5,
  input  logic        branch,
  input  logic        mem_read,
  input  logic        mem_to_reg,
  input  logic        mem_write,
  input  logic        alu_src,
  input  logic        reg_write,
  input  logic [1:0]  alu_op,
  output logic [63:0] rs1_data_d2,
  output logic [63:0] rs2_data_d2,
  output logic [63:0] immediate_d2,
  output logic [4:0]  rs1_d2,
  output logic [4:0]  rs2_d2,
  output logic [4:0]  rd_d2,
  output logic [2:0]  func3_d2,
  output logic        func7b5_d2,
  output logic        branch_d2,
  output logic        mem_read_d2,
  output logic        mem_to_reg_d2,
  output logic        mem_write_d2,
  output logic        alu_src_d2,
  output logic        reg_write_d2,
  output logic [1:0]  alu_op_d2
);

  // Load every cycle; a bubble clears only the control bits so no side effects escape
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs1_data_d2   <= '0;
      rs2_data_d2   <= '0;
      immediate_d2  <= '0;
      rs1_d2        <= '0;
      rs2_d2        <= '0;
      rd_d2         <= '0;
      func3_d2      <= '0;
      func7b5_d2    <= 1'b0;
      branch_d2     <= 1'b0;
      mem_read_d2   <= 1'b0;
      mem_to_reg_d2 <= 1'b0;
      mem_write_d2  <= 1'b0;
      alu_src_d2    <= 1'b0;
      reg_write_d2  <= 1'b0;
      alu_op_d2     <= '0;
    end else begin
      rs1_data_d2   <= rs1_data;
      rs2_data_d2   <= rs2_data;
      immediate_d2  <= immediate;
      rs1_d2        <= rs1;
      rs2_d2        <= rs2;
      rd_d2         <= rd;
      func3_d2      <= func3;
      func7b5_d2    <= func7b5;
      branch_d2     <= idex_bubble ? 1'b0 : branch;
      mem_read_d2   <= idex_bubble ? 1'b0 : mem_read;
      mem_to_reg_d2 <= idex_bubble ? 1'b0 : mem_to_reg;
      mem_write_d2  <= idex_bubble ? 1'b0 : mem_write;
      alu_src_d2    <= idex_bubble ? 1'b0 : alu_src;
      reg_write_d2  <= idex_bubble ? 1'b0 : reg_write;
      alu_op_d2     <= idex_bubble ? 2'b00 : alu_op;
    end
  end

endmodule

// File: rtl/ifid_reg.sv
// rtl/ifid_reg.sv - IF/ID instruction register with stall hold
module ifid_reg
  import core_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ifid_write,
  input  logic [31:0] instruction,
  output logic [31:0] instruction_d
);

  // Capture the fetched instruction unless stalled; reset to a NOP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instruction_d <= NOP_INSTR;
    end else if (ifid_write) begin
      instruction_d <= instruction;
    end
  end

endmodule

// File: rtl/id_ex_pipeline_slice.sv
// rtl/id_ex_pipeline_slice.sv - IF/ID and ID/EX registers feeding the execute stage
module id_ex_pipeline_slice (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic        ifid_write,
  input  logic        idex_bubble,
  input  logic [63:0] rs1_data,
  input  logic [63:0] rs2_data,
  input  logic [63:0] immediate,
  input  logic        branch,
  input  logic        mem_read,
  input  logic        mem_to_reg,
  input  logic        mem_write,
  input  logic        alu_src,
  input  logic        reg_write,
  input  logic [1:0]  alu_op,
  output logic [31:0] instruction_d,
  output logic [63:0] rs1_data_d2,
  output logic [63:0] rs2_data_d2,
  output logic [63:0] immediate_d2,
  output logic [4:0]  rs1_d2,
  output logic [4:0]  rs2_d2,
  output logic [4:0]  rd_d2,
  output logic [2:0]  func3_d2,
  output logic        func7b5_d2,
  output logic        branch_d2,
  output logic        mem_read_d2,
  output logic        mem_to_reg_d2,
  output logic        mem_write_d2,
  output logic        alu_src_d2,
  output logic        reg_write_d2,
  output logic [1:0]  alu_op_d2,
  output logic [3:0]  alu_ctrl,
  output logic [63:0] alu_result,
  output logic        alu_zero
);

  ifid_reg u_ifid (
    .clk           (clk),
    .rst           (rst),
    .ifid_write    (ifid_write),
    .instruction   (instruction),
    .instruction_d (instruction_d)
  );

  idex_reg u_idex (
    .clk           (clk),
    .rst           (rst),
    .idex_bubble   (idex_bubble),
    .rs1_data      (rs1_data),
    .rs2_data      (rs2_data),
    .immediate     (immediate),
    .rs1           (instruction_d[19:15]),
    .rs2           (instruction_d[24:20]),
    .rd            (instruction_d[11:7]),
    .func3         (instruction_d[14:12]),
    .func7b5       (instruction_d[30]),
    .branch        (branch),
    .mem_read      (mem_read),
    .mem_to_reg    (mem_to_reg),
    .mem_write     (mem_write),
    .alu_src       (alu_src),
    .reg_write     (reg_write),
    .alu_op        (alu_op),
    .rs1_data_d2   (rs1_data_d2),
    .rs2_data_d2   (rs2_data_d2),
    .immediate_d2  (immediate_d2),
    .rs1_d2        (rs1_d2),
    .rs2_d2        (rs2_d2),
    .rd_d2         (rd_d2),
    .func3_d2      (func3_d2),
    .func7b5_d2    (func7b5_d2),
    .branch_d2     (branch_d2),
    .mem_read_d2   (mem_read_d2),
    .mem_to_reg_d2 (mem_to_reg_d2),
    .mem_write_d2  (mem_write_d2),
    .alu_src_d2    (alu_src_d2),
    .reg_write_d2  (reg_write_d2),
    .alu_op_d2     (alu_op_d2)
  );

  execute_stage u_ex (
    .rs1_data_d2  (rs1_data_d2),
    .rs2_data_d2  (rs2_data_d2),
    .immediate_d2 (immediate_d2),
    .func3_d2     (func3_d2),
    .func7b5_d2   (func7b5_d2),
    .alu_src_d2   (alu_src_d2),
    .alu_op_d2    (alu_op_d2),
    .alu_ctrl     (alu_ctrl),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero)
  );

endmodule

// File: tb/tb_id_ex_pipeline_slice.sv
// tb/tb_id_ex_pipeline_slice.sv - directed vector bench for id_ex_pipeline_slice
module tb_id_ex_pipeline_slice;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction;
  logic        ifid_write;
  logic        idex_bubble;
  logic [63:0] rs1_data, rs2_data, immediate;
  logic        branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
  logic [1:0]  alu_op;
  logic [31:0] instruction_d;
  logic [63:0] rs1_data_d2, rs2_data_d2, immediate_d2;
  logic [4:0]  rs1_d2, rs2_d2, rd_d2;
  logic [2:0]  func3_d2;
  logic        func7b5_d2;
  logic        branch_d2, mem_read_d2, mem_to_reg_d2, mem_write_d2, alu_src_d2, reg_write_d2;
  logic [1:0]  alu_op_d2;
  logic [3:0]  alu_ctrl;
  logic [63:0] alu_result;
  logic        alu_zero;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic        f7b5;
    logic [1:0]  op;
    logic        src;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] imm;
    logic [3:0]  exp_ctrl;
    logic [63:0] exp_res;
    logic        exp_zero;
  } vec_t;

  vec_t vecs[16];

  id_ex_pipeline_slice dut (
    .clk(clk), .rst(rst), .instruction(instruction), .ifid_write(ifid_write),
    .idex_bubble(idex_bubble), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .immediate(immediate), .branch(branch), .mem_read(mem_read),
    .mem_to_reg(mem_to_reg), .mem_write(mem_write), .alu_src(alu_src),
    .reg_write(reg_write), .alu_op(alu_op), .instruction_d(instruction_d),
    .rs1_data_d2(rs1_data_d2), .rs2_data_d2(rs2_data_d2), .immediate_d2(immediate_d2),
    .rs1_d2(rs1_d2), .rs2_d2(rs2_d2), .rd_d2(rd_d2), .func3_d2(func3_d2),
    .func7b5_d2(func7b5_d2), .branch_d2(branch_d2), .mem_read_d2(mem_read_d2),
    .mem_to_reg_d2(mem_to_reg_d2), .mem_write_d2(mem_write_d2),
    .alu_src_d2(alu_src_d2), .reg_write_d2(reg_write_d2), .alu_op_d2(alu_op_d2),
    .alu_ctrl(alu_ctrl), .alu_result(alu_result), .alu_zero(alu_zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    vecs[0]  = '{"sub_r",    3'b000, 1'b1, 2'b10, 1'b0, 64'd7, 64'd5, 64'd0, 4'b0110, 64'd2, 1'b0};
    vecs[1]  = '{"add_r",    3'b000, 1'b0, 2'b10, 1'b0, 64'd7, 64'd5, 64'd0, 4'b0010, 64'd12, 1'b0};
    vecs[2]  = '{"load",     3'b011, 1'b0, 2'b00, 1'b1, 64'd16, 64'd99, 64'hFFFF_FFFF_FFFF_FFF8, 4'b0010, 64'd8, 1'b0};
    vecs[3]  = '{"addi_b10", 3'b000, 1'b1, 2'b10, 1'b1, 64'd7, 64'd5, 64'h400, 4'b0010, 64'h407, 1'b0};
    vecs[4]  = '{"beq_eq",   3'b000, 1'b0, 2'b01, 1'b0, 64'h1234, 64'h1234, 64'd0, 4'b0110, 64'd0, 1'b1};
    vecs[5]  = '{"beq_ne",   3'b000, 1'b0, 2'b01, 1'b0, 64'h1234, 64'h1235, 64'd0, 4'b0110, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[6]  = '{"sra",      3'b101, 1'b1, 2'b10, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 64'd0, 4'b0111, 64'hF800_0000_0000_0000, 1'b0};
    vecs[7]  = '{"srl",      3'b101, 1'b0, 2'b10, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 64'd0, 4'b0101, 64'h0800_0000_0000_0000, 1'b0};
    vecs[8]  = '{"sltu",     3'b011, 1'b0, 2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'b1001, 64'd0, 1'b1};
    vecs[9]  = '{"slt",      3'b010, 1'b0, 2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'b1000, 64'd1, 1'b0};
    vecs[10] = '{"sll_b6",   3'b001, 1'b0, 2'b10, 1'b0, 64'd1, 64'h43, 64'd0, 4'b0100, 64'd8, 1'b0};
    vecs[11] = '{"xor",      3'b100, 1'b0, 2'b10, 1'b0, 64'hF0, 64'hFF, 64'd0, 4'b0011, 64'h0F, 1'b0};
    vecs[12] = '{"or",       3'b110, 1'b0, 2'b10, 1'b0, 64'hF0, 64'hFF, 64'd0, 4'b0001, 64'hFF, 1'b0};
    vecs[13] = '{"and",      3'b111, 1'b0, 2'b10, 1'b0, 64'hF0, 64'hFF, 64'd0, 4'b0000, 64'hF0, 1'b0};
    vecs[14] = '{"rsvd_op",  3'b100, 1'b1, 2'b11, 1'b0, 64'd3, 64'd4, 64'd0, 4'b0010, 64'd7, 1'b0};
    vecs[15] = '{"srai",     3'b101, 1'b1, 2'b10, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 64'd0, 64'd2, 4'b0111, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};

    rst = 1'b1; instruction = 32'h0; ifid_write = 1'b1; idex_bubble = 1'b0;
    rs1_data = '0; rs2_data = '0; immediate = '0;
    branch = 0; mem_read = 0; mem_to_reg = 0; mem_write = 0; alu_src = 0; reg_write = 0;
    alu_op = 2'b00;
    tick(); tick();

    chk("rst_instr_d", {32'd0, instruction_d}, 64'h13);
    chk("rst_rs1_d2", rs1_data_d2, 64'd0);
    chk("rst_alu_ctrl", {60'd0, alu_ctrl}, 64'b0010);
    chk("rst_alu_zero", {63'd0, alu_zero}, 64'd1);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 16; i++) begin
      instruction = {1'b0, vecs[i].f7b5, 5'd0, 5'd2, 5'd1, vecs[i].f3, 5'd3, 7'h33};
      ifid_write = 1'b1;
      tick();
      rs1_data = vecs[i].a; rs2_data = vecs[i].b; immediate = vecs[i].imm;
      alu_op = vecs[i].op; alu_src = vecs[i].src;
      tick();
      chk({vecs[i].name, "_ctrl"}, {60'd0, alu_ctrl}, {60'd0, vecs[i].exp_ctrl});
      chk({vecs[i].name, "_res"}, alu_result, vecs[i].exp_res);
      chk({vecs[i].name, "_zero"}, {63'd0, alu_zero}, {63'd0, vecs[i].exp_zero});
      chk({vecs[i].name, "_f3"}, {61'd0, func3_d2}, {61'd0, vecs[i].f3});
      chk({vecs[i].name, "_f7b5"}, {63'd0, func7b5_d2}, {63'd0, vecs[i].f7b5});
      chk({vecs[i].name, "_regs"}, {49'd0, rs1_d2, rs2_d2, rd_d2}, {49'd0, 5'd1, 5'd2, 5'd3});
    end

    // Stall with simultaneous bubble: IF/ID holds, ID/EX loads data but drops control
    instruction = 32'hABCD_0113; ifid_write = 1'b1;
    tick();
    chk("stall_load", {32'd0, instruction_d}, 64'hABCD_0113);
    ifid_write = 1'b0; idex_bubble = 1'b1;
    reg_write = 1'b1; mem_write = 1'b1; branch = 1'b1; mem_read = 1'b1;
    mem_to_reg = 1'b1; alu_src = 1'b1; alu_op = 2'b10;
    for (int c = 0; c < 3; c++) begin
      instruction = 32'h1111_0000 + c;
      rs1_data = 64'h55 + c;
      tick();
      chk("stall_hold", {32'd0, instruction_d}, 64'hABCD_0113);
      chk("bubble_ctrl", {55'd0, branch_d2, mem_read_d2, mem_to_reg_d2, mem_write_d2,
                          alu_src_d2, reg_write_d2, alu_op_d2, 1'b0}, 64'd0);
      chk("bubble_data", rs1_data_d2, 64'h55 + c);
    end
    ifid_write = 1'b1; idex_bubble = 1'b0; instruction = 32'h0000_0033;
    tick();
    chk("stall_release", {32'd0, instruction_d}, 64'h33);
    chk("unbubble_ctrl", {62'd0, reg_write_d2, mem_write_d2}, 64'b11);

    // Asynchronous reset asserted mid-cycle
    #2;
    rst = 1'b1;
    #1;
    chk("async_instr_d", {32'd0, instruction_d}, 64'h13);
    chk("async_d2", {rs1_data_d2[31:0], 22'd0, reg_write_d2, mem_write_d2, rd_d2, rs1_d2}, 64'd0);
    chk("async_alu", {alu_result[59:0], alu_ctrl}, 64'b0010);
    chk("async_zero", {63'd0, alu_zero}, 64'd1);
    tick();
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
